ptp_rst_seq: RTL

Reset and clock-mode sequencer for the PTPv2 core, running in the bus clock domain. It owns the TX clock-select line (GE/FE) and the per-domain reset requests for the RTC, TX and RX domains. On power-on, on a software reset pulse or on an MII-mode change, it asserts the domain resets, switches the clock select while those domains are held in reset, waits for the clock to settle, then releases the resets in a fixed staggered order. Destination domains synchronize the deassertion of `*_n_o` locally.

---
 rtl/ptp_rst_seq.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ptp_rst_seq.sv
// Reset and TX clock-select sequencer for the PTPv2 core (bus clock domain).
// Holds RTC/TX/RX domains in reset across a GE/FE clock switch, then releases them staggered.
module ptp_rst_seq #(
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned SETTLE_CYCLES  = 64,
    parameter int unsigned STAGGER_CYCLES = 4,
    parameter int unsigned CNT_W          = 8
) (
    input  logic bus_clk,
    input  logic rst_sys_n,
    input  logic mii_mode_i,
    input  logic sw_rst_i,
    output logic clk_sel_o,
    output logic rst_rtc_n_o,
    output logic rst_tx_n_o,
    output logic rst_rx_n_o,
    output logic busy_o,
    output logic done_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_ASSERT, S_SWITCH, S_SETTLE, S_REL_RTC, S_REL_TX, S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_mode_meta;
    logic             r_mode_sync;
    logic             r_full;
    logic             r_clk_sel;
    logic             r_rst_rtc_n;
    logic             r_rst_tx_n;
    logic             r_rst_rx_n;
    logic             r_busy;
    logic             r_done;
    logic             w_full_nxt;
    logic             w_clk_sel_nxt;
    logic             w_rst_rtc_n_nxt;
    logic             w_rst_tx_n_nxt;
    logic             w_rst_rx_n_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_trig;
    logic             w_entry;

    // Two-flop synchronizer for the asynchronous mode request
    always_ff @(posedge bus_clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_mode_meta <= 1'b0;
            r_mode_sync <= 1'b0;
        end else begin
            r_mode_meta <= mii_mode_i;
            r_mode_sync <= r_mode_meta;
        end
    end

    // Power-on behaves as an ASSERT already in progress with the full flag set
    always_ff @(posedge bus_clk or negedge rst_sys_n) begin
        if (!rst_sys_n) r_state <= S_ASSERT;
        else            r_state <= w_state_nxt;
    end

    assign w_trig = sw_rst_i | (r_mode_sync != r_clk_sel);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_trig) w_state_nxt = S_ASSERT;
            S_ASSERT:  if (r_cnt == HOLD_LAST) w_state_nxt = S_SWITCH;
            S_SWITCH:  w_state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (w_trig)                   w_state_nxt = S_ASSERT;
                else if (r_cnt == SETTLE_LAST) w_state_nxt = r_full ? S_REL_RTC : S_REL_TX;
            end
            S_REL_RTC: begin
                if (w_trig)                    w_state_nxt = S_ASSERT;
                else if (r_cnt == STAGGER_LAST) w_state_nxt = S_REL_TX;
            end
            S_REL_TX: begin
                if (w_trig)                    w_state_nxt = S_ASSERT;
                else if (r_cnt == STAGGER_LAST) w_state_nxt = S_DONE;
            end
            S_DONE:    w_state_nxt = w_trig ? S_ASSERT : S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    assign w_entry = (w_state_nxt != r_state);

    // Next values of the registered outputs, applied on state-entry edges
    always_comb begin
        w_cnt_nxt       = r_cnt;
        w_full_nxt      = r_full | sw_rst_i;
        w_clk_sel_nxt   = r_clk_sel;
        w_rst_rtc_n_nxt = r_rst_rtc_n;
        w_rst_tx_n_nxt  = r_rst_tx_n;
        w_rst_rx_n_nxt  = r_rst_rx_n;
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_done_nxt      = 1'b0;

        if (w_entry) begin
            w_cnt_nxt = '0;
        end else if (r_state inside {S_ASSERT, S_SETTLE, S_REL_RTC, S_REL_TX}) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end

        if (w_state_nxt == S_IDLE) w_full_nxt = 1'b0;
        if (r_state == S_SWITCH)   w_clk_sel_nxt = r_mode_sync;

        if (w_entry) begin
            case (w_state_nxt)
                S_ASSERT: begin
                    w_rst_tx_n_nxt = 1'b0;
                    w_rst_rx_n_nxt = 1'b0;
                    if (w_full_nxt) w_rst_rtc_n_nxt = 1'b0;
                end
                S_REL_RTC: w_rst_rtc_n_nxt = 1'b1;
                S_REL_TX:  w_rst_tx_n_nxt  = 1'b1;
                S_DONE: begin
                    w_rst_rx_n_nxt = 1'b1;
                    w_done_nxt     = 1'b1;
                end
                default: ;
            endcase
        end else if (r_state == S_ASSERT && sw_rst_i) begin
            w_rst_rtc_n_nxt = 1'b0;
        end
    end

    always_ff @(posedge bus_clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_cnt       <= '0;
            r_full      <= 1'b1;
            r_clk_sel   <= 1'b0;
            r_rst_rtc_n <= 1'b0;
            r_rst_tx_n  <= 1'b0;
            r_rst_rx_n  <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_full      <= w_full_nxt;
            r_clk_sel   <= w_clk_sel_nxt;
            r_rst_rtc_n <= w_rst_rtc_n_nxt;
            r_rst_tx_n  <= w_rst_tx_n_nxt;
            r_rst_rx_n  <= w_rst_rx_n_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign clk_sel_o   = r_clk_sel;
    assign rst_rtc_n_o = r_rst_rtc_n;
    assign rst_tx_n_o  = r_rst_tx_n;
    assign rst_rx_n_o  = r_rst_rx_n;
    assign busy_o      = r_busy;
    assign done_o      = r_done;

endmodule
